// File: rtl/insn_fetch_unit_if.sv
// Instruction memory fetch bus: request/address out, ack/data back.
// The fetch unit is the master; the instruction memory is the slave.
interface insn_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/insn_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time over req/ack and holds it until retired.
// Optional opcode screening is enabled by defining ILLEGAL_OPCODE_TRAP_EN.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for mem_ack
// HOLD  | insn valid, waiting for exec_done to advance pc
// FAULT | misaligned next pc or illegal opcode; left only through rst
module insn_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  insn_fetch_unit_if.master     mem,
  output logic [31:0]           insn,
  output logic                  insn_valid,
  output logic [31:0]           insn_pc,
  input  logic                  exec_done,
  input  logic                  pc_next_sel,
  input  logic [31:0]           pc_target,
  output logic                  misaligned,
  output logic                  illegal_insn,
  output logic [31:0]           instret
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] insn_pc_q, insn_pc_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] pc_next;
  logic        opcode_ok;

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic illegal_q, illegal_d;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
      7'b0010111, 7'b1110011, 7'b0001111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign opcode_ok    = is_rv32i_opcode(mem.mem_rdata[6:0]);
  assign illegal_insn = illegal_q;
`else
  assign opcode_ok    = 1'b1;
  assign illegal_insn = 1'b0;
`endif

  // Wraps mod 2^32 naturally, so 0xFFFFFFFC + 4 lands on 0.
  assign pc_next = pc_next_sel ? pc_target : (pc_q + 32'd4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    insn_d       = insn_q;
    insn_pc_d    = insn_pc_q;
    valid_d      = valid_q;
    misaligned_d = misaligned_q;
    instret_d    = instret_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    illegal_d    = illegal_q;
`endif
    case (state_q)
      FETCH: begin
        if (mem.mem_ack) begin
          insn_pc_d = pc_q;
          if (opcode_ok) begin
            insn_d  = mem.mem_rdata;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
            illegal_d = 1'b1;
`endif
            state_d   = FAULT;
          end
        end
      end
      HOLD: begin
        if (exec_done) begin
          valid_d = 1'b0;
          insn_d  = NOP_INSN;
          if (pc_next[1:0] == 2'b00) begin
            pc_d      = pc_next;
            instret_d = instret_q + 32'd1;
            state_d   = FETCH;
          end else begin
            misaligned_d = 1'b1;
            state_d      = FAULT;
          end
        end
      end
      FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      insn_q       <= NOP_INSN;
      insn_pc_q    <= RESET_PC;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      instret_q    <= 32'd0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      insn_q       <= insn_d;
      insn_pc_q    <= insn_pc_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      instret_q    <= instret_d;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

  // Request is gated by rst combinationally so nothing is issued during reset.
  assign mem.mem_req  = (state_q == FETCH) && !rst;
  assign mem.mem_addr = pc_q;
  assign insn         = insn_q;
  assign insn_valid   = valid_q;
  assign insn_pc      = insn_pc_q;
  assign misaligned   = misaligned_q;
  assign instret      = instret_q;

endmodule

// File: doc/insn_fetch_unit.md
Name: insn_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoders.
- Owns the program counter and issues read requests to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register and presents it as INSN with a valid flag.
- Holds INSN until the execute side signals completion, then advances the PC to PC+4 or to the target selected by pc_next_sel.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSN, 32'h0000_0013: IR contents while no instruction is valid (addi x0,x0,0).

Ports:
- CLK  in  1  processor clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- mem_addr  out  32  instruction fetch address; always equals pc.
- mem_req  out  1  fetch request.
- mem_ack  in  1  memory has the word for mem_addr on mem_rdata this cycle.
- mem_rdata  in  32  instruction word from memory.
- insn  out  32  instruction register, drives decoder INSN.
- insn_valid  out  1  insn is a fetched, not-yet-retired instruction.
- insn_pc  out  32  address insn was fetched from.
- exec_done  in  1  execute stage finished the instruction in insn.
- pc_next_sel  in  1  0: next PC = PC+4; 1: next PC = pc_target.
- pc_target  in  32  branch/jump target from PC ALU.
- misaligned  out  1  sticky fault: next PC not word aligned.
- illegal_insn  out  1  sticky fault: illegal opcode (optional feature).
- instret  out  32  retired-instruction counter.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- Reset values:
  - state = FETCH, pc = RESET_PC, insn = NOP_INSN, insn_pc = RESET_PC.
  - insn_valid = 0, misaligned = 0, illegal_insn = 0, instret = 0.
  - mem_req is forced 0 while RST is high.
- States: FETCH, HOLD, FAULT.
- mem_req = 1 only in FETCH with RST low. mem_addr = pc combinationally in all states.
- FETCH:
  - mem_ack = 0: stay in FETCH. mem_req stays 1 and pc stays stable, for any number of wait cycles.
  - mem_ack = 1: insn <= mem_rdata, insn_pc <= pc, insn_valid <= 1, go to HOLD. Zero-wait ack in the same cycle as the request is legal.
- HOLD:
  - insn and insn_valid remain stable until exec_done = 1.
  - On exec_done: next = pc_next_sel ? pc_target : pc + 4. The addition is mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - If next[1:0] == 0: pc <= next, instret <= instret + 1 (wraps mod 2^32), insn_valid <= 0, insn <= NOP_INSN, go to FETCH.
  - If next[1:0] != 0: misaligned <= 1, insn_valid <= 0, insn <= NOP_INSN, go to FAULT. pc and instret are unchanged.
- FAULT: mem_req = 0, insn_valid = 0. The block leaves FAULT only through RST.
- Ignored inputs: mem_ack outside FETCH; exec_done outside HOLD; pc_next_sel and pc_target when exec_done = 0.
- Throughput: minimum 2 cycles per instruction (ack cycle, then exec_done cycle).
- Reset mid-operation: RST overrides everything on that edge. An outstanding fetch is abandoned; an ack arriving in the RST cycle is dropped. The first request after RST deasserts is to RESET_PC.

Optional Feature:
- Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - When FETCH receives mem_ack, mem_rdata[6:0] is checked against the RV32I opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111.
  - No match: illegal_insn <= 1, insn_pc <= pc, insn stays NOP_INSN, insn_valid stays 0, go to FAULT.
- Undefined: no opcode check, every acked word is presented; illegal_insn is tied to 0.

Test Plan:
- Reset, RESET_PC=0x100, RST high for 2 cycles, then low -> mem_addr=0x100, mem_req=1, insn_valid=0, insn=0x00000013, instret=0.
- Zero-wait fetch: mem_ack=1 in the first FETCH cycle, mem_rdata=0x002081B3 -> next cycle insn=0x002081B3, insn_valid=1, insn_pc=0x100. Then exec_done=1, pc_next_sel=0 -> mem_addr=0x104, insn_valid=0, instret=1.
- Wait states: mem_ack delayed 3 cycles at 0x104 -> mem_req=1 and mem_addr=0x104 held for all 4 cycles, insn_valid=0. HOLD with exec_done low for 5 cycles -> insn unchanged.
- Branch: pc_next_sel=1, pc_target=0x200 -> next fetch at 0x200. Next instruction with pc_target=0x202 -> misaligned=1, mem_req=0, stays faulted until RST.
- Wrap: RESET_PC=0xFFFFFFFC, one instruction retired with pc_next_sel=0 -> mem_addr=0x00000000.
- RST asserted mid-FETCH stall at 0x104 with mem_ack=1 in the same cycle -> word dropped, mem_addr=RESET_PC, instret=0. With ILLEGAL_OPCODE_TRAP_EN defined, acked word 0x00000000 -> illegal_insn=1, insn_valid=0, mem_req=0.
